// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : store_unit
//  Purpose  : Store path from the execute stage to data memory. It takes
//             SB/SH/SW requests, moves rs2 data into the correct byte lanes
//             and builds the byte write mask. Legal stores wait in a small
//             in-order FIFO until memory accepts them over a valid/ready
//             handshake. Misaligned or illegal stores are consumed and
//             reported. A load-address word match is offered as a hazard.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             req_valid/req_ready  - request handshake (ready = not full)
//             req_funct3/addr/data - store type, byte address, rs2 value
//             st_misaligned        - one-cycle pulse after a rejected store
//             mem_valid/mem_ready  - drain handshake for the FIFO head
//             mem_addr/wdata/wmask - word address, lane data, byte enables
//             ld_addr/ld_hit       - load address and word-match hazard
//             busy                 - FIFO non-empty
//  Revision : 1.0 - initial release
// ============================================================================
module store_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  output logic          st_misaligned,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [2:0]    c_f3_sb = 3'b000;
  logic [2:0]    c_f3_sh = 3'b001;
  logic [2:0]    c_f3_sw = 3'b010;

  // Per-entry storage
  logic          r_vld   [DEPTH];
  logic [AW-3:0] r_waddr [DEPTH];
  logic [31:0]   r_wdata [DEPTH];
  logic [3:0]    r_wmask [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_misaligned;

  logic          w_legal;
  logic [3:0]    w_mask;
  logic [31:0]   w_data;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_off;
  logic [DEPTH-1:0] w_hit;
  logic          w_unused;

  assign w_off     = req_addr[1:0];
  assign req_ready = (r_count != C_FULL);
  assign mem_valid = (r_count != '0);
  assign busy      = mem_valid;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && w_legal;
  assign w_pop     = mem_valid && mem_ready;
  assign st_misaligned = r_misaligned;

  // Only the word part of the load address takes part in the match.
  assign w_unused  = ^ld_addr[1:0];

  // Lane alignment and legality of the incoming request
  always_comb begin
    w_legal = 1'b0;
    w_mask  = 4'b0000;
    w_data  = 32'h0;
    if (req_funct3 == c_f3_sb) begin
      w_legal = 1'b1;
      w_mask  = 4'b0001 << w_off;
      w_data  = {4{req_data[7:0]}};
    end else if (req_funct3 == c_f3_sh) begin
      w_legal = ~w_off[0];
      w_mask  = w_off[1] ? 4'b1100 : 4'b0011;
      w_data  = {2{req_data[15:0]}};
    end else if (req_funct3 == c_f3_sw) begin
      w_legal = (w_off == 2'b00);
      w_mask  = 4'b1111;
      w_data  = req_data;
    end
  end

  // Outputs are forced to zero while empty so stale entries never show.
  assign mem_addr  = mem_valid ? {r_waddr[r_head], 2'b00} : '0;
  assign mem_wdata = mem_valid ? r_wdata[r_head] : 32'h0;
  assign mem_wmask = mem_valid ? r_wmask[r_head] : 4'b0000;

  // Word-match hazard over stored entries; the head still counts while it
  // is being popped, and an entry being accepted does not count yet.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign w_hit[i] = r_vld[i] && (r_waddr[i] == ld_addr[AW-1:2]);
    end
  endgenerate
  assign ld_hit = |w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]   <= 1'b0;
        r_waddr[i] <= '0;
        r_wdata[i] <= 32'h0;
        r_wmask[i] <= 4'b0000;
      end
    end else begin
      r_misaligned <= w_accept && !w_legal;
      // Push only happens when not full, so tail never equals a head that
      // is being popped in the same cycle.
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_push) begin
        r_vld[r_tail]   <= 1'b1;
        r_waddr[r_tail] <= req_addr[AW-1:2];
        r_wdata[r_tail] <= w_data;
        r_wmask[r_tail] <= w_mask;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_unit
//  Purpose  : Self-checking bench for store_unit. Directed scenarios are
//             followed by a random phase; all outputs are compared every
//             cycle against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_unit;

  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic          st_misaligned;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic          busy;

  store_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data),
    .st_misaligned(st_misaligned),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  ent_t q[$];
  bit   exp_mis;
  int   n_cmp;
  int   n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Store semantics written directly from the byte-lane rules.
  function automatic void model_req(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d, output bit legal,
                                    output logic [3:0] m, output logic [31:0] wd);
    int off;
    off   = int'(a % 4);
    legal = 0;
    m     = 4'h0;
    wd    = 32'h0;
    case (f3)
      3'd0: begin legal = 1; m = 4'(1 << off); wd = (d & 32'hFF) * 32'h0101_0101; end
      3'd1: begin legal = (off % 2 == 0); m = (off == 2) ? 4'hC : 4'h3;
                  wd = (d & 32'hFFFF) * 32'h0001_0001; end
      3'd2: begin legal = (off == 0); m = 4'hF; wd = d; end
      default: legal = 0;
    endcase
  endfunction

  function automatic bit model_hit(input logic [31:0] la);
    foreach (q[i]) if ((q[i].addr >> 2) == (la >> 2)) return 1;
    return 0;
  endfunction

  task automatic check_all();
    chk("req_ready", req_ready, q.size() < DEPTH);
    chk("mem_valid", mem_valid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("st_misaligned", st_misaligned, exp_mis);
    chk("ld_hit", ld_hit, model_hit(ld_addr));
    chk("mem_addr", mem_addr, q.size() != 0 ? q[0].addr : 32'h0);
    chk("mem_wdata", mem_wdata, q.size() != 0 ? q[0].data : 32'h0);
    chk("mem_wmask", mem_wmask, q.size() != 0 ? q[0].mask : 4'h0);
  endtask

  // One clock: drive at the falling edge, check ld_hit before the rising
  // edge, update the model at the rising edge, check everything after it.
  task automatic cycle(input bit v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit mr, input logic [31:0] la,
                       input bit r);
    bit          acc, pop, legal;
    logic [3:0]  m;
    logic [31:0] wd;
    rst = r; req_valid = v; req_funct3 = f3; req_addr = a; req_data = d;
    mem_ready = mr; ld_addr = la;
    #1;
    chk("ld_hit_pre", ld_hit, model_hit(la));
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_mis = 0;
    end else begin
      model_req(f3, a, d, legal, m, wd);
      acc = v && (q.size() < DEPTH);
      pop = (q.size() != 0) && mr;
      exp_mis = acc && !legal;
      if (pop) void'(q.pop_front());
      if (acc && legal) q.push_back('{addr: a & ~32'h3, data: wd, mask: m});
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit mr, input logic [31:0] la);
    cycle(0, 3'd0, 32'h0, 32'h0, mr, la, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_mis = 0;
    rst = 1; req_valid = 0; req_funct3 = 0; req_addr = 0; req_data = 0;
    mem_ready = 0; ld_addr = 0;
    @(negedge clk);

    // Reset state
    cycle(0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 1);
    cycle(0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 1);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // SB to top byte lane
    cycle(1, 3'd0, 32'h1003, 32'h0000_00AB, 0, 32'h0, 0);
    chk("t1_valid", mem_valid, 1'b1);
    chk("t1_addr", mem_addr, 32'h1000);
    chk("t1_mask", mem_wmask, 4'b1000);
    chk("t1_byte", mem_wdata[31:24], 8'hAB);
    idle(1, 32'h0);

    // SH upper half, then misaligned SH
    cycle(1, 3'd1, 32'h2002, 32'hFFFF_1234, 0, 32'h0, 0);
    chk("t2_mask", mem_wmask, 4'b1100);
    chk("t2_half", mem_wdata[31:16], 16'h1234);
    chk("t2_addr", mem_addr, 32'h2000);
    idle(1, 32'h0);
    cycle(1, 3'd1, 32'h2001, 32'hFFFF_1234, 0, 32'h0, 0);
    chk("t2_mis", st_misaligned, 1'b1);
    chk("t2_novalid", mem_valid, 1'b0);
    idle(0, 32'h0);
    chk("t2_mis_pulse", st_misaligned, 1'b0);

    // SW held under back-pressure
    cycle(1, 3'd2, 32'h3000, 32'hDEAD_BEEF, 0, 32'h0, 0);
    idle(0, 32'h0);
    idle(0, 32'h0);
    chk("t3_hold", mem_wdata, 32'hDEAD_BEEF);
    idle(1, 32'h0);
    chk("t3_popped", busy, 1'b0);

    // Fill to full, then drain in order
    cycle(1, 3'd2, 32'h100, 32'h1, 0, 32'h0, 0);
    cycle(1, 3'd2, 32'h104, 32'h2, 0, 32'h0, 0);
    chk("t4_full", req_ready, 1'b0);
    cycle(1, 3'd2, 32'h108, 32'h3, 0, 32'h0, 0);
    cycle(1, 3'd2, 32'h108, 32'h3, 1, 32'h0, 0);
    chk("t4_second", mem_wdata, 32'h2);
    cycle(1, 3'd2, 32'h108, 32'h3, 1, 32'h0, 0);
    chk("t4_third", mem_wdata, 32'h3);
    idle(1, 32'h0);

    // Load hazard
    cycle(1, 3'd2, 32'h4004, 32'h55, 0, 32'h4004, 0);
    idle(0, 32'h4006);
    chk("t5_hit", ld_hit, 1'b1);
    idle(0, 32'h4008);
    chk("t5_miss", ld_hit, 1'b0);
    idle(1, 32'h4006);
    chk("t5_after_pop", ld_hit, 1'b0);

    // Reset mid-drain
    cycle(1, 3'd2, 32'h500, 32'hA, 0, 32'h0, 0);
    cycle(1, 3'd2, 32'h504, 32'hB, 0, 32'h0, 0);
    cycle(0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 1);
    chk("t6_valid", mem_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", req_ready, 1'b1);
    idle(1, 32'h500);
    idle(1, 32'h504);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7) < 6 ? $urandom_range(0, 2) : $urandom_range(3, 7)),
            32'h5000 + 32'($urandom_range(0, 15)),
            32'($urandom),
            $urandom_range(0, 2) != 0,
            32'h5000 + 32'($urandom_range(0, 15)),
            $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
